// File: rtl/mm_pkg.sv
// Shared types and sizes for the matrix-multiply job arbiter.
package mm_pkg;
    localparam int BYTE_W       = 8;
    localparam int MM_IN_BYTES  = 18;
    localparam int MM_OUT_BYTES = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_LOAD,
        S_WAIT,
        S_DRAIN,
        S_ABORT,
        S_RELEASE
    } state_t;

    // A single client still needs a 1-bit pointer/index.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search starts at client (ptr+1) mod NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_win
);
    logic w_found;

    always_comb begin
        o_win   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && (j == ((int'(i_ptr) + 1 + i) % NUM_REQ))) begin
                    o_win[j] = 1'b1;
                    w_found  = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/mm_job_arbiter.sv
// Time-shares one 3x3 matrix-multiply core between NUM_REQ clients, one job at a time.
// States: IDLE wait req | GRANT start pulse | LOAD stream operands | WAIT core latency
//         DRAIN return results | ABORT core hung | RELEASE job end, rotate pointer
module mm_job_arbiter
    import mm_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int IN_BYTES    = MM_IN_BYTES,
    parameter int OUT_BYTES   = MM_OUT_BYTES,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic [BYTE_W*NUM_REQ-1:0] opnd_data,
    output logic [NUM_REQ-1:0]        opnd_rd,
    output logic [BYTE_W-1:0]         res_data,
    output logic [NUM_REQ-1:0]        res_valid,
    output logic [NUM_REQ-1:0]        job_done,
    output logic                      job_err,
    output logic                      mm_start,
    output logic                      mm_rst,
    output logic [BYTE_W-1:0]         mm_data_in,
    input  logic [BYTE_W-1:0]         mm_data_out,
    input  logic                      mm_done
);
    localparam int PTR_W = ptr_width(NUM_REQ);

    state_t              r_state;
    logic [PTR_W-1:0]    r_g;
    logic [PTR_W-1:0]    r_ptr;
    logic [4:0]          r_cnt;
    logic [3:0]          r_ocnt;
    logic [7:0]          r_tcnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_opnd_rd;
    logic [NUM_REQ-1:0]  r_res_valid;
    logic [NUM_REQ-1:0]  r_job_done;
    logic                r_job_err;
    logic                r_mm_start;
    logic                r_mm_rst;
    logic [BYTE_W-1:0]   r_mm_data_in;
    logic [BYTE_W-1:0]   r_res_data;

    logic [NUM_REQ-1:0]  w_win;
    logic [PTR_W-1:0]    w_win_idx;
    logic [BYTE_W-1:0]   w_opnd_byte;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_win   (w_win)
    );

    always_comb begin
        w_win_idx = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (w_win[j]) w_win_idx = PTR_W'(j);
        end
    end

    always_comb begin
        w_opnd_byte = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_g == PTR_W'(j)) w_opnd_byte = opnd_data[BYTE_W*j +: BYTE_W];
        end
    end

    // Pops run one cycle ahead of LOAD so byte k reaches the core at GRANT+1+k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_g          <= '0;
            r_ptr        <= PTR_W'(NUM_REQ - 1);
            r_cnt        <= '0;
            r_ocnt       <= '0;
            r_tcnt       <= '0;
            r_gnt        <= '0;
            r_opnd_rd    <= '0;
            r_res_valid  <= '0;
            r_job_done   <= '0;
            r_job_err    <= 1'b0;
            r_mm_start   <= 1'b0;
            r_mm_rst     <= 1'b1;
            r_mm_data_in <= '0;
            r_res_data   <= '0;
        end else begin
            r_mm_start  <= 1'b0;
            r_mm_rst    <= 1'b0;
            r_res_valid <= '0;
            r_job_done  <= '0;
            r_job_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_g        <= w_win_idx;
                        r_gnt      <= w_win;
                        r_opnd_rd  <= w_win;
                        r_mm_start <= 1'b1;
                        r_state    <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_cnt        <= '0;
                    r_ocnt       <= '0;
                    r_tcnt       <= '0;
                    r_mm_data_in <= w_opnd_byte;
                    r_state      <= S_LOAD;
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'(IN_BYTES - 2)) r_opnd_rd <= '0;
                    if (r_cnt == 5'(IN_BYTES - 1)) begin
                        r_mm_data_in <= '0;
                        r_state      <= S_WAIT;
                    end else begin
                        r_mm_data_in <= w_opnd_byte;
                    end
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 8'd1;
                    if (mm_done) begin
                        r_res_data  <= mm_data_out;
                        r_res_valid <= r_gnt;
                        r_ocnt      <= 4'd1;
                        r_state     <= S_DRAIN;
                    end else if (r_tcnt == 8'(TIMEOUT_CYC - 1)) begin
                        r_mm_rst   <= 1'b1;
                        r_job_err  <= 1'b1;
                        r_job_done <= r_gnt;
                        r_state    <= S_ABORT;
                    end
                end
                S_DRAIN: begin
                    if (r_ocnt == 4'(OUT_BYTES)) begin
                        r_job_done <= r_gnt;
                        r_state    <= S_RELEASE;
                    end else if (mm_done) begin
                        r_res_data  <= mm_data_out;
                        r_res_valid <= r_gnt;
                        r_ocnt      <= r_ocnt + 4'd1;
                    end
                end
                S_ABORT: begin
                    r_gnt   <= '0;
                    r_state <= S_IDLE;
                end
                S_RELEASE: begin
                    r_gnt   <= '0;
                    r_ptr   <= r_g;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign opnd_rd    = r_opnd_rd;
    assign res_data   = r_res_data;
    assign res_valid  = r_res_valid;
    assign job_done   = r_job_done;
    assign job_err    = r_job_err;
    assign mm_start   = r_mm_start;
    assign mm_rst     = rst | r_mm_rst;
    assign mm_data_in = r_mm_data_in;
endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed bench for mm_job_arbiter with a behavioural core stub and FWFT client models.
module tb_mm_job_arbiter;
    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [15:0] opnd_data;
    logic [1:0]  opnd_rd;
    logic [7:0]  res_data;
    logic [1:0]  res_valid;
    logic [1:0]  job_done;
    logic        job_err;
    logic        mm_start;
    logic        mm_rst;
    logic [7:0]  mm_data_in;
    logic [7:0]  mm_data_out;
    logic        mm_done;

    int n_checks = 0;
    int n_errors = 0;
    int cidx[2];
    int stub_mode;
    int viol;
    int mrst_cnt;

    mm_job_arbiter #(
        .NUM_REQ     (2),
        .IN_BYTES    (18),
        .OUT_BYTES   (9),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .opnd_data   (opnd_data),
        .opnd_rd     (opnd_rd),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .job_done    (job_done),
        .job_err     (job_err),
        .mm_start    (mm_start),
        .mm_rst      (mm_rst),
        .mm_data_in  (mm_data_in),
        .mm_data_out (mm_data_out),
        .mm_done     (mm_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // client 0 serves 1,2,3..., client 1 serves 0x41,0x42...
    assign opnd_data = {8'(32'h41 + cidx[1]), 8'(32'h01 + cidx[0])};

    initial begin : client_model
        logic [1:0] pop;
        forever begin
            @(negedge clk);
            pop = opnd_rd;
            @(posedge clk);
            #1;
            if (pop[0]) cidx[0]++;
            if (pop[1]) cidx[1]++;
        end
    end

    // mode 0: 9 back-to-back results; mode 1: mm_done toggles; mode 2: never answers
    initial begin : core_stub
        mm_done     = 1'b0;
        mm_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (mm_start && stub_mode != 2) begin
                repeat (21) @(negedge clk);
                for (int k = 0; k < 9; k++) begin
                    mm_done     = 1'b1;
                    mm_data_out = 8'hA0 + 8'(k);
                    @(negedge clk);
                    mm_done     = 1'b0;
                    mm_data_out = 8'h00;
                    if (stub_mode == 1) @(negedge clk);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        int c;
        c = 0;
        do begin
            tick();
            c++;
        end while (gnt == 2'b00 && c < 60);
        g = gnt;
    endtask

    // Follows a granted job to job_done; cyc counts cycles since the call.
    task automatic collect(input logic [1:0] g, input bit drop, output int n, output int cyc);
        n        = 0;
        cyc      = 0;
        viol     = 0;
        mrst_cnt = 0;
        while (cyc < 400) begin
            tick();
            cyc++;
            if (res_valid != 2'b00) begin
                if (res_valid != g) viol++;
                if (res_data != 8'hA0 + n[7:0]) viol++;
                n++;
                if (drop) req = 2'b00;
            end
            if (gnt != g || mm_start) viol++;
            if (mm_rst) mrst_cnt++;
            if (job_done != 2'b00) break;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin : main
        logic [1:0] g;
        int n;
        int cyc;
        int seen;

        rst       = 1'b1;
        req       = 2'b00;
        stub_mode = 0;
        cidx[0]   = 0;
        cidx[1]   = 0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_mm_rst", 32'(mm_rst), 32'h1);
        chk("rst_ctrl", 32'({opnd_rd, res_valid, job_done, job_err, mm_start}), 32'h0);
        chk("rst_data", 32'({mm_data_in, res_data}), 32'h0);
        rst = 1'b0;
        tick();
        chk("mm_rst_release", 32'(mm_rst), 32'h0);

        // single job, operand stream timing and result return
        req = 2'b01;
        wait_gnt(g);
        chk("t1_gnt", 32'(g), 32'h1);
        chk("t1_start", 32'(mm_start), 32'h1);
        req = 2'b00;
        for (int k = 0; k < 18; k++) begin
            tick();
            chk("t1_din", 32'(mm_data_in), 32'(k + 1));
        end
        collect(2'b01, 1'b0, n, cyc);
        chk("t1_nres", 32'(n), 32'd9);
        chk("t1_done_cyc", 32'(cyc + 18), 32'd31);
        chk("t1_done", 32'(job_done), 32'h1);
        chk("t1_err", 32'(job_err), 32'h0);
        chk("t1_viol", 32'(viol), 32'h0);
        tick();
        chk("t1_gnt_drop", 32'(gnt), 32'h0);

        // contention with both requests held from reset
        req = 2'b11;
        do_reset();
        for (int j = 0; j < 4; j++) begin
            wait_gnt(g);
            chk("t2_order", 32'(g), (j % 2 == 0) ? 32'h1 : 32'h2);
            collect(g, 1'b0, n, cyc);
            chk("t2_nres", 32'(n), 32'd9);
            chk("t2_viol", 32'(viol), 32'h0);
        end
        req = 2'b00;

        // core never answers
        do_reset();
        stub_mode = 2;
        cidx[0]   = 0;
        req       = 2'b01;
        wait_gnt(g);
        chk("t3_gnt", 32'(g), 32'h1);
        req = 2'b00;
        collect(2'b01, 1'b0, n, cyc);
        chk("t3_abort_cyc", 32'(cyc), 32'd274);
        chk("t3_err", 32'(job_err), 32'h1);
        chk("t3_mm_rst", 32'(mm_rst), 32'h1);
        chk("t3_done", 32'(job_done), 32'h1);
        chk("t3_mrst_pulses", 32'(mrst_cnt), 32'h1);
        chk("t3_nres", 32'(n), 32'h0);
        tick();
        chk("t3_after", 32'({gnt, mm_rst, job_err, job_done}), 32'h0);

        // stalled drain
        stub_mode = 1;
        req       = 2'b01;
        wait_gnt(g);
        chk("t4_gnt", 32'(g), 32'h1);
        req = 2'b00;
        collect(2'b01, 1'b0, n, cyc);
        chk("t4_nres", 32'(n), 32'd9);
        chk("t4_done_cyc", 32'(cyc), 32'd39);
        chk("t4_viol", 32'(viol), 32'h0);

        // reset during LOAD
        do_reset();
        stub_mode = 2;
        cidx[0]   = 0;
        req       = 2'b01;
        wait_gnt(g);
        chk("t5_gnt", 32'(g), 32'h1);
        req = 2'b00;
        repeat (7) tick();
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", 32'({gnt, opnd_rd, mm_start, res_valid, job_done}), 32'h0);
        chk("t5_rst_din", 32'(mm_data_in), 32'h0);
        chk("t5_rst_mm_rst", 32'(mm_rst), 32'h1);
        tick();
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (job_done != 2'b00) seen++;
        end
        chk("t5_no_done", 32'(seen), 32'h0);

        // client 1 request, dropped during DRAIN
        stub_mode = 0;
        cidx[1]   = 0;
        req       = 2'b10;
        wait_gnt(g);
        chk("t5_regrant", 32'(g), 32'h2);
        collect(2'b10, 1'b1, n, cyc);
        chk("t6_nres", 32'(n), 32'd9);
        chk("t6_done", 32'(job_done), 32'h2);
        chk("t6_done_cyc", 32'(cyc), 32'd31);
        chk("t6_viol", 32'(viol), 32'h0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt != 2'b00) seen++;
        end
        chk("t6_no_regrant", 32'(seen), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
